// File: rtl/sgf_seq_divider_pkg.sv
// Shared definitions for the sequential significand divider: FSM encodings and width helper.
package sgf_seq_divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int SW_DEF = 24;
  localparam int FW_DEF = 24;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sgf_seq_divider_if.sv
// Request/result bundle between the FPU divide sequencer and the significand divider.
interface sgf_seq_divider_if #(
  parameter int SW = 24,
  parameter int FW = 24
);
  logic               start_i;
  logic [SW-1:0]      Data_A_i;
  logic [SW-1:0]      Data_B_i;
  logic               ready_o;
  logic               done_o;
  logic [SW+FW-1:0]   sgf_quot_o;
  logic [SW-1:0]      sgf_rem_o;
  logic               sticky_o;
  logic               div_zero_o;

  modport master (
    output start_i, Data_A_i, Data_B_i,
    input  ready_o, done_o, sgf_quot_o, sgf_rem_o, sticky_o, div_zero_o
  );

  modport slave (
    input  start_i, Data_A_i, Data_B_i,
    output ready_o, done_o, sgf_quot_o, sgf_rem_o, sticky_o, div_zero_o
  );
endinterface

// File: rtl/sgf_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module sgf_div_step #(
  parameter int SW = 24
) (
  input  logic [SW-1:0] p_rem,
  input  logic          in_bit,
  input  logic [SW-1:0] b,
  output logic [SW-1:0] p_next,
  output logic          qbit
);

  logic [SW:0] t;

  assign t    = {p_rem, in_bit};
  assign qbit = (t >= {1'b0, b});
  // P_rem < B keeps the difference below 2^SW, so truncation is lossless.
  assign p_next = qbit ? SW'(t - {1'b0, b}) : t[SW-1:0];

endmodule

// File: rtl/sgf_seq_divider.sv
// Radix-2 restoring divider: Q = floor({A, FW zeros} / B), one quotient bit per clock.
module sgf_seq_divider
  import sgf_seq_divider_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sgf_seq_divider_if.slave  bus
);

  localparam int N  = SW + FW;
  localparam int CW = clog2(N + 1);

  state_t        state;
  logic [SW-1:0] b_r;
  logic [SW-1:0] p_rem;
  logic [SW-1:0] p_next;
  logic [N-1:0]  dvd;
  logic [N-1:0]  q_work;
  logic [CW-1:0] cnt;
  logic          qbit;
  logic          accept;

  logic [N-1:0]  quot_r;
  logic [SW-1:0] rem_r;
  logic          sticky_r;
  logic          dz_r;

  assign accept = bus.start_i && (state != ST_CALC);

  sgf_div_step #(.SW(SW)) u_step (
    .p_rem  (p_rem),
    .in_bit (dvd[N-1]),
    .b      (b_r),
    .p_next (p_next),
    .qbit   (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      b_r      <= '0;
      p_rem    <= '0;
      dvd      <= '0;
      q_work   <= '0;
      cnt      <= '0;
      quot_r   <= '0;
      rem_r    <= '0;
      sticky_r <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            b_r    <= bus.Data_B_i;
            dvd    <= N'(bus.Data_A_i) << FW;
            p_rem  <= '0;
            q_work <= '0;
            cnt    <= '0;
            if (bus.Data_B_i == '0) begin
              // Divide by zero short-circuits straight to a saturated result.
              state    <= ST_DONE;
              quot_r   <= '1;
              rem_r    <= '0;
              sticky_r <= 1'b0;
              dz_r     <= 1'b1;
            end else begin
              state <= ST_CALC;
              dz_r  <= 1'b0;
            end
          end else if (state == ST_DONE) begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          p_rem  <= p_next;
          dvd    <= dvd << 1;
          q_work <= N'({q_work, qbit});
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state    <= ST_DONE;
            quot_r   <= N'({q_work, qbit});
            rem_r    <= p_next;
            sticky_r <= |p_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_o    = (state != ST_CALC);
  assign bus.done_o     = (state == ST_DONE);
  assign bus.sgf_quot_o = quot_r;
  assign bus.sgf_rem_o  = rem_r;
  assign bus.sticky_o   = sticky_r;
  assign bus.div_zero_o = dz_r;

endmodule
